seg_instruction_fetch: RTL and testbench

SEG_INSTRUCTION_FETCH -- requirements
Module: seg_instruction_fetch

---
 rtl/seg_instruction_fetch.sv | 115 +++++++++++
 tb/tb_seg_instruction_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_instruction_fetch.sv
// Instruction fetch stage: program memory, PC register and IF/ID pipeline register.
// Program is loaded in IDLE, fetched in RUN, and fetch stops once the halt word is issued.
module seg_instruction_fetch #(
  parameter int             LEN        = 32,
  parameter int             NB_ADDR    = 10,
  parameter logic [LEN-1:0] HALT_INSTR = 32'hFFFFFFFF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_wr_en,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [LEN-1:0]     i_wr_data,
  input  logic               i_stall,
  input  logic               i_pc_src,
  input  logic [LEN-1:0]     i_branch_addr,
  input  logic               i_jump,
  input  logic [LEN-1:0]     i_jump_addr,
  output logic [LEN-1:0]     o_instruc,
  output logic [LEN-1:0]     o_pc_next,
  output logic [LEN-1:0]     o_pc,
  output logic               o_valid,
  output logic               o_halt
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t             state_q, state_d;
  logic [LEN-1:0]     pc_q, pc_d;
  logic [LEN-1:0]     instr_q, instr_d;
  logic [LEN-1:0]     pc_next_q, pc_next_d;
  logic               valid_q, valid_d;
  logic               halt_q, halt_d;

  logic [LEN-1:0]     mem [2**NB_ADDR];
  logic [NB_ADDR-1:0] rd_idx;
  logic [LEN-1:0]     fetched;
  logic [LEN-1:0]     pc_plus4;
  logic               redirect;

  // Byte-addressed PC; the low two bits never select a word.
  assign rd_idx   = pc_q[NB_ADDR+1:2];
  assign fetched  = mem[rd_idx];
  assign pc_plus4 = pc_q + LEN'(4);
  assign redirect = i_jump | i_pc_src;

  always_ff @(posedge i_clk) begin
    if (state_q == IDLE && i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    halt_d    = halt_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (i_start) state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          // Redirect wins over stall; the wrong-path word is squashed.
          pc_d      = i_jump ? i_jump_addr : i_branch_addr;
          instr_d   = '0;
          pc_next_d = '0;
          valid_d   = 1'b0;
        end else if (!i_stall) begin
          pc_d      = pc_plus4;
          instr_d   = fetched;
          pc_next_d = pc_plus4;
          valid_d   = 1'b1;
          if (fetched == HALT_INSTR) begin
            state_d = HALT;
            halt_d  = 1'b1;
          end
        end
      end
      HALT: begin
        instr_d = '0;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
      halt_q    <= halt_d;
    end
  end

  assign o_pc      = pc_q;
  assign o_instruc = instr_q;
  assign o_pc_next = pc_next_q;
  assign o_valid   = valid_q;
  assign o_halt    = halt_q;

endmodule

// File: tb/tb_seg_instruction_fetch.sv
// Directed bench for seg_instruction_fetch: a rule-level fetch model checked every
// cycle, plus hand-computed literal expectations along the directed scenarios.
module tb_seg_instruction_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [9:0]  i_wr_addr = '0;
  logic [31:0] i_wr_data = '0;
  logic        i_stall = 1'b0;
  logic        i_pc_src = 1'b0;
  logic [31:0] i_branch_addr = '0;
  logic        i_jump = 1'b0;
  logic [31:0] i_jump_addr = '0;
  logic [31:0] o_instruc, o_pc_next, o_pc;
  logic        o_valid, o_halt;

  int checks = 0;
  int errors = 0;

  seg_instruction_fetch dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_stall(i_stall), .i_pc_src(i_pc_src), .i_branch_addr(i_branch_addr),
    .i_jump(i_jump), .i_jump_addr(i_jump_addr),
    .o_instruc(o_instruc), .o_pc_next(o_pc_next), .o_pc(o_pc),
    .o_valid(o_valid), .o_halt(o_halt)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: mode 0=idle, 1=run, 2=halted.
  int          m_mode = 0;
  logic [31:0] m_pc = '0, m_instr = '0, m_pcn = '0;
  logic        m_valid = 1'b0, m_halt = 1'b0;
  logic [31:0] m_mem [1024];

  initial foreach (m_mem[i]) m_mem[i] = '0;

  task automatic model_reset();
    m_mode = 0; m_pc = '0; m_instr = '0; m_pcn = '0; m_valid = 1'b0; m_halt = 1'b0;
  endtask

  always @(negedge i_rst) model_reset();

  always @(posedge i_clk) begin
    logic [31:0] word;
    if (!i_rst) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (i_wr_en) m_mem[i_wr_addr] = i_wr_data;
      if (i_start) m_mode = 1;
    end else if (m_mode == 1) begin
      word = m_mem[(m_pc >> 2) % 1024];
      if (i_jump || i_pc_src) begin
        m_pc = i_jump ? i_jump_addr : i_branch_addr;
        m_instr = '0; m_pcn = '0; m_valid = 1'b0;
      end else if (!i_stall) begin
        m_instr = word; m_pcn = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        if (word == 32'hFFFFFFFF) begin m_mode = 2; m_halt = 1'b1; end
      end
    end else begin
      m_instr = '0; m_valid = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    chk("model_pc", o_pc, m_pc);
    chk("model_instruc", o_instruc, m_instr);
    chk("model_valid", {31'd0, o_valid}, {31'd0, m_valid});
    chk("model_halt", {31'd0, o_halt}, {31'd0, m_halt});
    if (m_valid) chk("model_pc_next", o_pc_next, m_pcn);
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pc"}, o_pc, 32'h0);
    chk({tag, "_instruc"}, o_instruc, 32'h0);
    chk({tag, "_pc_next"}, o_pc_next, 32'h0);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'h0);
    chk({tag, "_halt"}, {31'd0, o_halt}, 32'h0);
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] ins, input logic [31:0] pcn,
                           input logic [31:0] pc);
    chk({tag, "_instruc"}, o_instruc, ins);
    chk({tag, "_pc_next"}, o_pc_next, pcn);
    chk({tag, "_pc"}, o_pc, pc);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
  endtask

  task automatic flush_chk(input string tag, input logic [31:0] pc);
    chk({tag, "_pc"}, o_pc, pc);
    chk({tag, "_instruc"}, o_instruc, 32'h0);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
  endtask

  task automatic start_run();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    chk_zero("reset");
    i_rst = 1'b1;
    load(10'd0, 32'h01094020);
    load(10'd1, 32'h8C034020);
    load(10'd2, 32'hAC040005);
    load(10'd3, 32'hFFFFFFFF);
    for (int k = 8; k < 12; k++) load(10'(k), 32'h20080000 + 32'(k));
    for (int k = 16; k < 20; k++) load(10'(k), 32'h30090000 + 32'(k));
    load(10'd1023, 32'h12345678);
    chk("idle_valid", {31'd0, o_valid}, 32'd0);
    chk("idle_pc", o_pc, 32'h0);

    // Straight-line program ending in halt
    start_run();
    chk("start_pc", o_pc, 32'h0);
    tick(); fetch_chk("prog0", 32'h01094020, 32'h4, 32'h4);
    tick(); fetch_chk("prog1", 32'h8C034020, 32'h8, 32'h8);
    tick(); fetch_chk("prog2", 32'hAC040005, 32'hC, 32'hC);
    tick(); fetch_chk("prog3", 32'hFFFFFFFF, 32'h10, 32'h10);
    chk("halt_set", {31'd0, o_halt}, 32'd1);
    tick(); flush_chk("halt_after", 32'h10);
    chk("halt_stays", {31'd0, o_halt}, 32'd1);
    i_jump = 1'b1; i_jump_addr = 32'h40; i_stall = 1'b1;
    i_wr_en = 1'b1; i_wr_addr = 10'd2; i_wr_data = 32'hDEADBEEF;
    tick(); flush_chk("halt_ignore", 32'h10);
    i_jump = 1'b0; i_stall = 1'b0; i_wr_en = 1'b0;

    // Stall at PC=8 with an ignored RUN-time write
    i_rst = 1'b0; tick(); i_rst = 1'b1;
    start_run();
    tick(); tick(); fetch_chk("pre_stall", 32'h8C034020, 32'h8, 32'h8);
    i_stall = 1'b1; i_wr_en = 1'b1; i_wr_addr = 10'd1; i_wr_data = 32'hDEADBEEF;
    tick(); fetch_chk("stall1", 32'h8C034020, 32'h8, 32'h8);
    tick(); fetch_chk("stall2", 32'h8C034020, 32'h8, 32'h8);
    i_stall = 1'b0; i_wr_en = 1'b0;
    tick(); fetch_chk("resume", 32'hAC040005, 32'hC, 32'hC);

    // Asynchronous reset mid-RUN at PC=0xC
    i_rst = 1'b0; #1;
    chk_zero("async_rst");
    tick(); i_rst = 1'b1;
    start_run();
    tick(); fetch_chk("restart", 32'h01094020, 32'h4, 32'h4);

    // Branch at PC=4
    i_pc_src = 1'b1; i_branch_addr = 32'h20;
    tick(); flush_chk("branch", 32'h20);
    i_pc_src = 1'b0;
    tick(); fetch_chk("branch_tgt", 32'h20080008, 32'h24, 32'h24);

    // Jump beats branch, and both beat stall
    i_jump = 1'b1; i_jump_addr = 32'h40; i_pc_src = 1'b1; i_stall = 1'b1;
    tick(); flush_chk("jump_prio", 32'h40);
    i_jump = 1'b0; i_pc_src = 1'b0; i_stall = 1'b0;
    tick(); fetch_chk("jump_tgt", 32'h30090010, 32'h44, 32'h44);

    // Re-fetch mem[1]: the RUN-time write must not have landed
    i_jump = 1'b1; i_jump_addr = 32'h4;
    tick(); flush_chk("jump4", 32'h4);
    i_jump = 1'b0;
    tick(); fetch_chk("mem1_kept", 32'h8C034020, 32'h8, 32'h8);

    // Index wrap with ignored low bits, then PC+4 wrap
    i_jump = 1'b1; i_jump_addr = 32'h1002;
    tick(); i_jump = 1'b0;
    tick(); fetch_chk("idx_wrap", 32'h01094020, 32'h1006, 32'h1006);
    i_jump = 1'b1; i_jump_addr = 32'hFFFFFFFC;
    tick(); i_jump = 1'b0;
    tick(); fetch_chk("pc_wrap", 32'h12345678, 32'h0, 32'h0);
    tick(); fetch_chk("after_wrap", 32'h01094020, 32'h4, 32'h4);

    // Halt word squashed by a redirect does not halt
    tick(); tick();
    chk("at_halt_word_pc", o_pc, 32'hC);
    i_pc_src = 1'b1; i_branch_addr = 32'h0;
    tick(); flush_chk("halt_flushed", 32'h0);
    chk("no_halt", {31'd0, o_halt}, 32'd0);
    i_pc_src = 1'b0;
    tick(); tick(); tick(); tick();
    fetch_chk("halt_again", 32'hFFFFFFFF, 32'h10, 32'h10);
    chk("halt_again_flag", {31'd0, o_halt}, 32'd1);
    tick(); flush_chk("halt_frozen", 32'h10);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
